// File: rtl/rt_pkg.sv
// Shared ray-tracer definitions: camera fixed-point format, sequencer states,
// and the arithmetic helpers used by the pixel sequencer and its LFSR.
package rt_pkg;

  localparam int unsigned CAMERA_IW = 16;
  localparam int unsigned CAMERA_QW = 16;
  localparam int unsigned CAMERA_WL = CAMERA_IW + CAMERA_QW;

  // 0.5 in CAMERA_IW.CAMERA_QW fixed point
  localparam logic [CAMERA_WL-1:0] FP_HALF = CAMERA_WL'(1) << (CAMERA_QW - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } rt_seq_state_e;

  // One Galois right-shift step, polynomial x^32 + x^22 + x^2 + x + 1
  function automatic logic [31:0] lfsr32_step(input logic [31:0] v);
    logic [31:0] n;
    n     = {v[0], v[31:1]};
    n[21] = n[21] ^ v[0];
    n[1]  = n[1] ^ v[0];
    n[0]  = n[0] ^ v[0];
    return n;
  endfunction

  // Integer index to fixed point, plus an optional jitter of rnd/2^QW - 0.5
  function automatic logic [CAMERA_WL-1:0] fp_coord(input logic [CAMERA_IW-1:0] idx,
                                                    input logic [15:0]          rnd,
                                                    input logic                 jit);
    logic [CAMERA_WL-1:0] base;
    logic [CAMERA_WL-1:0] jit_v;
    base  = {idx, {CAMERA_QW{1'b0}}};
    jit_v = '0;
    if (jit) begin
      jit_v = CAMERA_WL'(rnd[CAMERA_QW-1:0]) - FP_HALF;
    end
    return base + jit_v;
  endfunction

endpackage

// File: rtl/rt_lfsr32.sv
// 32-bit Galois LFSR that advances only when step_i is high.
module rt_lfsr32
  import rt_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] seed,
  input  logic        step_i,
  output logic [31:0] value_o
);

  // Load seed on reset, advance one state per step
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_o <= seed;
    end else if (step_i) begin
      value_o <= lfsr32_step(value_o);
    end
  end

endmodule

// File: rtl/rt_pixel_seq.sv
// Pixel/sample sequencer: scans the image row-major with SPP samples per pixel
// and streams fixed-point (optionally jittered) coordinates to the ray generator.
module rt_pixel_seq
  import rt_pkg::*;
#(
  parameter int unsigned DIM_W = 11,
  parameter int unsigned SPP_W = 4,
  parameter logic [31:0] SEED  = 32'hACE1_2B3D
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [DIM_W-1:0]     width_i,
  input  logic [DIM_W-1:0]     height_i,
  input  logic [SPP_W-1:0]     spp_i,
  input  logic                 jitter_en_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CAMERA_WL-1:0] x_o,
  output logic [CAMERA_WL-1:0] y_o,
  output logic [DIM_W-1:0]     px_o,
  output logic [DIM_W-1:0]     py_o,
  output logic [SPP_W-1:0]     sample_o,
  output logic                 pix_last_o,
  output logic                 frame_last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  if (CAMERA_QW > 16 || CAMERA_IW <= DIM_W + 1) begin : g_bad_cfg
    $error("rt_pixel_seq: camera format cannot hold pixel indices plus jitter");
  end

  rt_seq_state_e    state_q;
  logic [DIM_W-1:0] cfg_w;
  logic [DIM_W-1:0] cfg_h;
  logic [SPP_W-1:0] cfg_spp;
  logic             cfg_jit;

  logic             accept;
  logic [31:0]      lfsr_val;
  logic [31:0]      lfsr_nx;
  logic [DIM_W-1:0] nx_px;
  logic [DIM_W-1:0] nx_py;
  logic [SPP_W-1:0] nx_smp;
  logic             nx_pix_last;
  logic             nx_frame_last;
  logic [SPP_W-1:0] start_spp;
  logic             start_ok;

  rt_lfsr32 u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .seed    (SEED),
    .step_i  (accept),
    .value_o (lfsr_val)
  );

  // Next-beat counters and flags; pix_last_o already encodes sample==SPP-1
  always_comb begin
    accept    = valid_o && ready_i;
    lfsr_nx   = lfsr32_step(lfsr_val);
    nx_smp    = sample_o + 1'b1;
    nx_px     = px_o;
    nx_py     = py_o;
    if (pix_last_o) begin
      nx_smp = '0;
      if (px_o == cfg_w - 1'b1) begin
        nx_px = '0;
        nx_py = py_o + 1'b1;
      end else begin
        nx_px = px_o + 1'b1;
      end
    end
    nx_pix_last   = (nx_smp == cfg_spp - 1'b1);
    nx_frame_last = nx_pix_last && (nx_px == cfg_w - 1'b1) && (nx_py == cfg_h - 1'b1);
    start_spp     = (spp_i == '0) ? SPP_W'(1) : spp_i;
    start_ok      = (width_i != '0) && (height_i != '0);
  end

  // Frame FSM with registered beat outputs; beats are precomputed so one can retire per clock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cfg_w        <= '0;
      cfg_h        <= '0;
      cfg_spp      <= '0;
      cfg_jit      <= 1'b0;
      valid_o      <= 1'b0;
      x_o          <= '0;
      y_o          <= '0;
      px_o         <= '0;
      py_o         <= '0;
      sample_o     <= '0;
      pix_last_o   <= 1'b0;
      frame_last_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            cfg_w   <= width_i;
            cfg_h   <= height_i;
            cfg_spp <= start_spp;
            cfg_jit <= jitter_en_i;
            if (start_ok) begin
              state_q      <= RUN;
              valid_o      <= 1'b1;
              busy_o       <= 1'b1;
              px_o         <= '0;
              py_o         <= '0;
              sample_o     <= '0;
              pix_last_o   <= (start_spp == SPP_W'(1));
              frame_last_o <= (start_spp == SPP_W'(1)) && (width_i == DIM_W'(1)) &&
                              (height_i == DIM_W'(1));
              x_o          <= fp_coord('0, lfsr_val[15:0], jitter_en_i);
              y_o          <= fp_coord('0, lfsr_val[31:16], jitter_en_i);
            end else begin
              state_q <= DONE;
              done_o  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (frame_last_o) begin
              state_q <= DONE;
              valid_o <= 1'b0;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              px_o         <= nx_px;
              py_o         <= nx_py;
              sample_o     <= nx_smp;
              pix_last_o   <= nx_pix_last;
              frame_last_o <= nx_frame_last;
              x_o          <= fp_coord(CAMERA_IW'(nx_px), lfsr_nx[15:0], cfg_jit);
              y_o          <= fp_coord(CAMERA_IW'(nx_py), lfsr_nx[31:16], cfg_jit);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_o  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rt_pixel_seq.sv
// Self-checking bench for rt_pixel_seq: table of frame configurations plus
// hand-written sequences for empty frames, start during RUN and mid-frame reset.
module tb_rt_pixel_seq;

  localparam logic [31:0] SEED = 32'hACE1_2B3D;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [10:0] width_i = '0;
  logic [10:0] height_i = '0;
  logic [3:0]  spp_i = '0;
  logic        jitter_en_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [31:0] x_o;
  logic [31:0] y_o;
  logic [10:0] px_o;
  logic [10:0] py_o;
  logic [3:0]  sample_o;
  logic        pix_last_o;
  logic        frame_last_o;
  logic        busy_o;
  logic        done_o;

  rt_pixel_seq #(
    .DIM_W (11),
    .SPP_W (4),
    .SEED  (SEED)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .width_i      (width_i),
    .height_i     (height_i),
    .spp_i        (spp_i),
    .jitter_en_i  (jitter_en_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .x_o          (x_o),
    .y_o          (y_o),
    .px_o         (px_o),
    .py_o         (py_o),
    .sample_o     (sample_o),
    .pix_last_o   (pix_last_o),
    .frame_last_o (frame_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] px;
    logic [10:0] py;
    logic [3:0]  smp;
    logic        pl;
    logic        fl;
    logic [31:0] x;
    logic [31:0] y;
  } beat_t;

  typedef struct {
    int w;
    int h;
    int spp;
    bit jit;
    int rmode;
    bit poke;
    bit rst;
    int nb;
  } vec_t;

  beat_t       sbq[$];
  vec_t        tbl[9];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          cyc = 0;
  int          fl_cyc = 0;
  logic [31:0] mlfsr = SEED;
  bit          jit_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_step(input logic [31:0] l);
    logic [31:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // Expected beat stream for one frame; model LFSR advances once per beat
  task automatic push_frame(input int w, input int h, input int spp, input bit jit);
    int    s;
    beat_t b;
    s = (spp == 0) ? 1 : spp;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        for (int k = 0; k < s; k++) begin
          b.px  = 11'(xx);
          b.py  = 11'(yy);
          b.smp = 4'(k);
          b.pl  = (k == s - 1);
          b.fl  = b.pl && (xx == w - 1) && (yy == h - 1);
          b.x   = 32'(xx) << 16;
          b.y   = 32'(yy) << 16;
          if (jit) begin
            b.x = b.x + {16'h0, mlfsr[15:0]} - 32'h0000_8000;
            b.y = b.y + {16'h0, mlfsr[31:16]} - 32'h0000_8000;
          end
          sbq.push_back(b);
          mlfsr = model_step(mlfsr);
        end
      end
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor: compare each accepted beat, and check holds while stalled
  logic        stall_q = 1'b0;
  logic [63:0] h_xy;
  logic [29:0] h_idx;
  beat_t       e;
  int          dx;
  int          dy;
  always @(negedge clk) begin
    if (!rst_ni) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_xy", {x_o, y_o}, h_xy);
        chk("hold_idx", {valid_o, pix_last_o, frame_last_o, px_o, py_o, sample_o}, h_idx);
      end
      if (valid_o && ready_i) begin
        n_acc++;
        chk("beat_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("px", px_o, e.px);
          chk("py", py_o, e.py);
          chk("sample", sample_o, e.smp);
          chk("pix_last", pix_last_o, e.pl);
          chk("frame_last", frame_last_o, e.fl);
          chk("x", x_o, e.x);
          chk("y", y_o, e.y);
          if (e.fl) fl_cyc = cyc;
          if (jit_chk) begin
            dx = $signed(x_o - {5'b0, px_o, 16'b0});
            dy = $signed(y_o - {5'b0, py_o, 16'b0});
            chk("jx_range", (dx >= -32768) && (dx < 32768), 1);
            chk("jy_range", (dy >= -32768) && (dy < 32768), 1);
          end
        end
        stall_q = 1'b0;
      end else if (valid_o) begin
        stall_q = 1'b1;
        h_xy    = {x_o, y_o};
        h_idx   = {valid_o, pix_last_o, frame_last_o, px_o, py_o, sample_o};
      end else begin
        stall_q = 1'b0;
      end
    end
  end

  function automatic logic pick_ready(input int rmode, input int it);
    if (rmode == 1) return ($urandom_range(0, 2) != 0);
    if (rmode == 2) return (it % 2 == 0);
    return 1'b1;
  endfunction

  task automatic reset_dut();
    rst_ni = 1'b0;
    sbq.delete();
    mlfsr = SEED;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int w, input int h, input int spp, input bit jit,
                           input int rmode, input bit poke, input int nb);
    int iters;
    int acc0;
    int budget;
    bit got_done;
    push_frame(w, h, spp, jit);
    acc0        = n_acc;
    jit_chk     = jit;
    budget      = nb * 8 + 100;
    width_i     = 11'(w);
    height_i    = 11'(h);
    spp_i       = 4'(spp);
    jitter_en_i = jit;
    start_i     = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("run_entry", {busy_o, valid_o}, 2'b11);
    iters    = 0;
    got_done = 1'b0;
    while (!got_done && iters < budget) begin
      ready_i = pick_ready(rmode, iters);
      if (poke && iters == 2) begin
        start_i  = 1'b1;
        width_i  = 11'd1;
        height_i = 11'd1;
        spp_i    = 4'd1;
      end
      if (poke && iters == 3) start_i = 1'b0;
      @(posedge clk);
      #1;
      iters++;
      if (done_o) got_done = 1'b1;
    end
    start_i = 1'b0;
    ready_i = 1'b0;
    chk("done_seen", got_done, 1);
    chk("beat_count", n_acc - acc0, nb);
    chk("done_latency", cyc, fl_cyc + 1);
    if (rmode == 0) chk("throughput_cycles", iters, nb);
    @(posedge clk);
    #1;
    chk("post_done", {done_o, busy_o, valid_o}, 3'b000);
    chk("sb_drained", sbq.size(), 0);
    if (!got_done) reset_dut();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int t;
    // w, h, spp, jit, ready mode (0 always, 1 random, 2 alternate), poke start in RUN, reset first, beats
    tbl[0] = '{3, 2, 1, 1'b0, 0, 1'b0, 1'b0, 6};
    tbl[1] = '{2, 1, 3, 1'b0, 1, 1'b1, 1'b0, 6};
    tbl[2] = '{4, 4, 4, 1'b1, 0, 1'b0, 1'b1, 64};
    tbl[3] = '{4, 4, 4, 1'b1, 1, 1'b0, 1'b1, 64};
    tbl[4] = '{2, 3, 0, 1'b0, 1, 1'b0, 1'b0, 6};
    tbl[5] = '{2047, 2, 1, 1'b0, 0, 1'b0, 1'b0, 4094};
    tbl[6] = '{1, 2047, 1, 1'b1, 0, 1'b0, 1'b0, 2047};
    tbl[7] = '{1, 1, 1, 1'b0, 0, 1'b0, 1'b0, 1};
    tbl[8] = '{5, 1, 15, 1'b1, 2, 1'b0, 1'b0, 75};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {valid_o, busy_o, done_o, pix_last_o, frame_last_o}, 5'b0);
    chk("reset_idx", {px_o, py_o, sample_o}, 26'b0);
    chk("reset_xy", {x_o, y_o}, 64'b0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst) reset_dut();
      run_frame(tbl[i].w, tbl[i].h, tbl[i].spp, tbl[i].jit, tbl[i].rmode, tbl[i].poke, tbl[i].nb);
    end

    // Empty frames: straight to DONE, no beats, LFSR untouched
    width_i  = 11'd0;
    height_i = 11'd5;
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("w0_done", {done_o, valid_o, busy_o}, 3'b100);
    @(posedge clk);
    #1;
    chk("w0_done_end", {done_o, valid_o, busy_o}, 3'b000);
    width_i  = 11'd3;
    height_i = 11'd0;
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("h0_done", {done_o, valid_o, busy_o}, 3'b100);
    @(posedge clk);
    #1;
    run_frame(2, 1, 2, 1'b1, 1, 1'b0, 4);

    // Asynchronous reset while the fifth of twelve beats is on the outputs
    push_frame(3, 2, 2, 1'b0);
    acc0        = n_acc;
    jit_chk     = 1'b0;
    width_i     = 11'd3;
    height_i    = 11'd2;
    spp_i       = 4'd2;
    jitter_en_i = 1'b0;
    start_i     = 1'b1;
    ready_i     = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    t = 0;
    while (n_acc - acc0 < 4 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    ready_i = 1'b0;
    chk("pre_rst_beats", n_acc - acc0, 4);
    chk("pre_rst_valid", valid_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_async", {valid_o, busy_o, done_o}, 3'b000);
    sbq.delete();
    mlfsr = SEED;
    @(posedge clk);
    #1;
    chk("rst_no_done", done_o, 0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    run_frame(2, 2, 1, 1'b1, 0, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
